acs_pm8: RTL and testbench

- Add-compare-select and path-metric stage of the 8-state (K=4, rate 1/2, hard-decision) Viterbi decoder.
- Sits directly downstream of the branch-metric units. It consumes, per received symbol, the four Hamming distances from the received pair to codewords 00, 01, 10 and 11.
- It updates eight registered path metrics and emits one survivor decision bit per state to the traceback memory, together with a wrapping symbol index used as the write address.

---
 rtl/vit_pkg.sv | 18 +
 rtl/acs_unit.sv | 24 ++
 rtl/acs_pm8.sv | 125 ++++++++++++
 tb/tb_acs_pm8.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// Shared trellis definitions for the 8-state K=4 rate-1/2 Viterbi decoder.
// Generators, state/branch-metric types and the branch codeword helper.
package vit_pkg;

  localparam int NUM_STATES = 8;
  localparam logic [3:0] G1 = 4'b1111;
  localparam logic [3:0] G0 = 4'b1101;

  typedef logic [2:0] state_t;
  typedef logic [1:0] bm_t;

  function automatic logic [1:0] branch_label(state_t s, logic u);
    logic [3:0] r;
    r = {u, s};
    return {^(r & G1), ^(r & G0)};
  endfunction

endpackage

// File: rtl/acs_unit.sv
// One add-compare-select butterfly half: two candidate metrics, pick the
// smaller, ties resolve to predecessor p0. Purely combinational.
module acs_unit
  import vit_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  bm_t             bm0_i,
  input  bm_t             bm1_i,
  output logic [PM_W:0]   pm_o,
  output logic            dec_o
);

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;

  assign cand0 = {1'b0, pm0_i} + (PM_W+1)'(bm0_i);
  assign cand1 = {1'b0, pm1_i} + (PM_W+1)'(bm1_i);
  assign dec_o = cand1 < cand0;
  assign pm_o  = dec_o ? cand1 : cand0;

endmodule

// File: rtl/acs_pm8.sv
// ACS and path-metric stage of the 8-state Viterbi decoder.
// VIT_BEST_STATE_EN adds a registered argmin of the new metrics.
module acs_pm8
  import vit_pkg::*;
#(
  parameter int PM_W    = 8,
  parameter int INIT_PM = 16,
  parameter int DEPTH   = 64,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [1:0]           bm00,
  input  logic [1:0]           bm01,
  input  logic [1:0]           bm10,
  input  logic [1:0]           bm11,
  output logic                 dec_valid,
  output logic [7:0]           dec,
  output logic [IW-1:0]        sym_idx,
  output logic [8*PM_W-1:0]    pm,
  output logic [2:0]           best_state
);

  localparam logic [PM_W:0] HALF = (PM_W+1)'(1) << (PM_W-1);

  function automatic logic [PM_W-1:0] init_val(int n);
    return (n == 0) ? '0 : PM_W'(INIT_PM);
  endfunction

  logic [PM_W-1:0] pm_q [NUM_STATES];
  logic [PM_W-1:0] base [NUM_STATES];
  logic [PM_W:0]   acs  [NUM_STATES];
  logic [PM_W:0]   nrm  [NUM_STATES];
  logic [7:0]      dec_d, dec_q;
  logic [7:0]      hi_w, ovf_w;
  logic            dv_q;
  logic [IW-1:0]   nxt_q, idx_q, base_idx;
  bm_t  [3:0]      bmv;

  assign bmv      = {bm11, bm10, bm01, bm00};
  assign base_idx = start ? '0 : nxt_q;

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam state_t     P0 = state_t'(2 * (n % 4));
    localparam state_t     P1 = state_t'(2 * (n % 4) + 1);
    localparam logic       U  = 1'(n / 4);
    localparam logic [1:0] L0 = branch_label(P0, U);
    localparam logic [1:0] L1 = branch_label(P1, U);

    // start reseeds the trellis so a same-cycle symbol sees the initial metrics
    assign base[n] = start ? init_val(n) : pm_q[n];

    acs_unit #(.PM_W(PM_W)) u_acs (
      .pm0_i (base[P0]),
      .pm1_i (base[P1]),
      .bm0_i (bmv[L0]),
      .bm1_i (bmv[L1]),
      .pm_o  (acs[n]),
      .dec_o (dec_d[n])
    );

    assign hi_w[n]  = acs[n] >= HALF;
    assign nrm[n]   = acs[n] - (&hi_w ? HALF : '0);
    assign ovf_w[n] = nrm[n][PM_W];
    assign pm[n*PM_W +: PM_W] = pm_q[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_STATES; n++) pm_q[n] <= init_val(n);
      dec_q <= '0;
      dv_q  <= 1'b0;
      nxt_q <= '0;
      idx_q <= '0;
    end else begin
      dv_q <= in_valid;
      if (in_valid) begin
        for (int n = 0; n < NUM_STATES; n++) pm_q[n] <= nrm[n][PM_W-1:0];
        dec_q <= dec_d;
        idx_q <= base_idx;
        nxt_q <= base_idx + IW'(1);
      end else if (start) begin
        for (int n = 0; n < NUM_STATES; n++) pm_q[n] <= init_val(n);
        idx_q <= '0;
        nxt_q <= '0;
      end
    end
  end

  assign dec       = dec_q;
  assign dec_valid = dv_q;
  assign sym_idx   = idx_q;

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst_n) in_valid |-> ovf_w == '0
  );

`ifdef VIT_BEST_STATE_EN
  logic [2:0]    best_d, best_q;
  logic [PM_W:0] bmin;

  always_comb begin
    best_d = '0;
    bmin   = nrm[0];
    for (int n = 1; n < NUM_STATES; n++) begin
      if (nrm[n] < bmin) begin
        bmin   = nrm[n];
        best_d = 3'(n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) best_q <= '0;
    else if (in_valid) best_q <= best_d;
  end

  assign best_state = best_q;
`else
  assign best_state = '0;
`endif

endmodule

// File: tb/tb_acs_pm8.sv
// Scoreboard bench for acs_pm8: directed vectors, queued expectations,
// independent forward-trellis reference model with raw (unnormalized) shadow.
module tb_acs_pm8;

  localparam int PW   = 6;
  localparam int HALF = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  bm00 = '0, bm01 = '0, bm10 = '0, bm11 = '0;
  logic        dec_valid;
  logic [7:0]  dec;
  logic [5:0]  sym_idx;
  logic [47:0] pm;
  logic [2:0]  best_state;

  acs_pm8 #(.PM_W(PW), .INIT_PM(16), .DEPTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .bm00       (bm00),
    .bm01       (bm01),
    .bm10       (bm10),
    .bm11       (bm11),
    .dec_valid  (dec_valid),
    .dec        (dec),
    .sym_idx    (sym_idx),
    .pm         (pm),
    .best_state (best_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]        dec;
    logic [5:0]        idx;
    logic [47:0]       pm;
    logic [2:0]        best;
    logic [7:0][15:0]  rdiff;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   m_pm[8];
  int   m_raw[8];
  int   m_idx;
  logic dv_ref;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [47:0] pack(input int a[8]);
    logic [47:0] p;
    p = '0;
    for (int n = 0; n < 8; n++) p[n*6 +: 6] = a[n][5:0];
    return p;
  endfunction

  function automatic void model_reset();
    m_pm  = '{0, 16, 16, 16, 16, 16, 16, 16};
    m_raw = '{0, 16, 16, 16, 16, 16, 16, 16};
    m_idx = 0;
  endfunction

  // forward sweep over (state, input); ascending s visits p0 before p1
  function automatic void acs_ref(input int cur[8], input int b[4],
                                  output int nx[8], output logic [7:0] d);
    for (int n = 0; n < 8; n++) begin
      nx[n] = 1 << 20;
      d[n]  = 1'b0;
    end
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < 2; u++) begin
        int n, c1, c0, c;
        n  = u * 4 + s / 2;
        c1 = u ^ ((s >> 2) & 1) ^ ((s >> 1) & 1) ^ (s & 1);
        c0 = u ^ ((s >> 2) & 1) ^ (s & 1);
        c  = cur[s] + b[c1 * 2 + c0];
        if (c < nx[n]) begin
          nx[n] = c;
          d[n]  = (s % 2) == 1;
        end
      end
    end
  endfunction

  task automatic tick(input logic st, input logic v,
                      input int b0, input int b1, input int b2, input int b3);
    int          b[4];
    int          nx[8], rx[8];
    logic [7:0]  d, rd;
    bit          allhi;
    exp_t        x;
    @(posedge clk);
    #1;
    if (!v && !st) chk("pm_hold", pm, pack(m_pm));
    start = st;
    in_valid = v;
    bm00 = 2'(b0);
    bm01 = 2'(b1);
    bm10 = 2'(b2);
    bm11 = 2'(b3);
    b = '{b0, b1, b2, b3};
    if (st) model_reset();
    if (v) begin
      acs_ref(m_pm, b, nx, d);
      acs_ref(m_raw, b, rx, rd);
      allhi = 1'b1;
      for (int n = 0; n < 8; n++) if (nx[n] < HALF) allhi = 1'b0;
      if (allhi) for (int n = 0; n < 8; n++) nx[n] -= HALF;
      x = '0;
      x.dec = d;
      x.idx = 6'(m_idx);
      x.pm = pack(nx);
      x.best = 3'd0;
      for (int n = 1; n < 8; n++) if (nx[n] < nx[x.best]) x.best = 3'(n);
      for (int n = 0; n < 8; n++) x.rdiff[n] = 16'(rx[n] - rx[0]);
      q.push_back(x);
      m_pm = nx;
      m_raw = rx;
      m_idx = (m_idx + 1) % 64;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dv_ref <= 1'b0;
    else dv_ref <= in_valid;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("dec_valid", dec_valid, dv_ref);
      if (dec_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_output actual=dec_valid required=none t=%0t", $time);
        end else begin
          bit dok;
          e = q.pop_front();
          chk("dec", dec, e.dec);
          chk("sym_idx", sym_idx, e.idx);
          chk("pm", pm, e.pm);
`ifdef VIT_BEST_STATE_EN
          chk("best_state", best_state, e.best);
`else
          chk("best_state_tied", best_state, 3'd0);
`endif
          dok = 1'b1;
          for (int n = 1; n < 8; n++)
            if (int'(pm[n*6 +: 6]) - int'(pm[5:0]) != int'($signed(e.rdiff[n])))
              dok = 1'b0;
          chk("pm_diff_vs_raw", dok, 1'b1);
        end
      end
    end
  end

  initial begin
    int acc;
    int hand[8];
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick(i == 0, 1'b1, 0, 1, 1, 2);
      if (i > 0) begin
        chk("clean_pm0", pm[5:0], 6'd0);
        chk("clean_dec0", dec[0], 1'b0);
        chk("clean_idx", sym_idx, 6'(i - 1));
      end
    end
    tick(0, 0, 0, 0, 0, 0);
    chk("clean_pm0", pm[5:0], 6'd0);
    chk("clean_dec0", dec[0], 1'b0);
    chk("clean_idx", sym_idx, 6'd9);
    tick(0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    hand = '{0, 16, 16, 16, 16, 16, 16, 16};
    chk("reset_pm", pm, pack(hand));
    chk("reset_dec_valid", dec_valid, 1'b0);
    chk("reset_sym_idx", sym_idx, 6'd0);
    chk("reset_dec", dec, 8'd0);
    chk("reset_best", best_state, 3'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    tick(1, 1, 1, 1, 1, 1);
    tick(0, 1, 2, 2, 2, 2);
    tick(0, 1, 2, 2, 2, 2);
    tick(0, 1, 1, 0, 0, 1);
    hand = '{5, 5, 5, 5, 5, 5, 5, 5};
    chk("tie_setup_pm", pm, pack(hand));
    tick(0, 0, 0, 0, 0, 0);
    chk("tie_dec0", dec[0], 1'b0);
    tick(1, 1, 1, 1, 1, 1);
    tick(0, 1, 2, 2, 2, 2);
    tick(0, 1, 2, 2, 2, 2);
    tick(0, 1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("tie_less_dec0", dec[0], 1'b1);

    for (int i = 0; i < 40; i++) tick(i == 0, 1'b1, 2, 2, 2, 2);
    tick(0, 0, 0, 0, 0, 0);

    acc = 0;
    while (acc < 70) begin
      logic v;
      int   r;
      v = (acc == 0) || ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 3);
      tick(acc == 0, v,
           ((r >> 1) & 1) + (r & 1),
           ((r >> 1) & 1) + ((r & 1) ^ 1),
           (((r >> 1) & 1) ^ 1) + (r & 1),
           (((r >> 1) & 1) ^ 1) + ((r & 1) ^ 1));
      if (v) acc++;
    end

    tick(1, 1, 1, 1, 1, 1);
    tick(0, 1, 0, 1, 1, 2);
    hand = '{1, 17, 17, 17, 1, 17, 17, 17};
    chk("collide_pm", pm, pack(hand));
    chk("collide_idx", sym_idx, 6'd0);
    tick(0, 0, 0, 0, 0, 0);
    chk("collide_next_idx", sym_idx, 6'd1);

    repeat (3) tick(0, 0, 0, 0, 0, 0);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
